// File: rtl/operand_sequencer.sv
// operand_sequencer: four-phase (IDLE/FETCH/EXEC/WRITE) single-instruction ALU sequencer driving a register file
//
// Ports:
//   clk                    rising-edge clock for all state
//   reset                  asynchronous active-low reset (0 = reset)
//   instr_valid/ready      instruction handshake; ready is high only in IDLE
//   opcode, rd, ra, rb     operation and register indices (latched on handshake)
//   imm                    8-bit immediate for LDI
//   address_a/address_b    register-file read addresses, non-zero only in FETCH
//   data_out_a/data_out_b  register-file read data (combinational)
//   write_enable, address_w, data_in_w  registered register-file write port, active only in WRITE
//   done                   one-cycle retirement pulse in WRITE
//   zero_flag, carry_flag  ALU flags, present only when OPERAND_SEQUENCER_FLAGS_EN is defined
//
// Build option: define OPERAND_SEQUENCER_FLAGS_EN to add the zero/carry flag outputs.
module operand_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [7:0]        imm,
    output logic [ADDR_W-1:0] address_a,
    output logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_out_a,
    input  logic [DATA_W-1:0] data_out_b,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address_w,
    output logic [DATA_W-1:0] data_in_w,
    output logic              done
`ifdef OPERAND_SEQUENCER_FLAGS_EN
    ,
    output logic              zero_flag,
    output logic              carry_flag
`endif
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [7:0]        imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] alu_res;

    assign sum = a_q + b_q;

    // NOP produces no result; a zero keeps the write-data bus quiet
    assign alu_res = op_q == OP_ADD ? sum :
                     op_q == OP_SUB ? a_q - b_q :
                     op_q == OP_AND ? a_q & b_q :
                     op_q == OP_OR  ? a_q | b_q :
                     op_q == OP_XOR ? a_q ^ b_q :
                     op_q == OP_MOV ? a_q :
                     op_q == OP_LDI ? DATA_W'(imm_q) : '0;

`ifdef OPERAND_SEQUENCER_FLAGS_EN
    logic carry_q;
    logic alu_cy;
    // a truncated sum smaller than an addend means the add wrapped
    assign alu_cy = op_q == OP_ADD ? sum < a_q :
                    op_q == OP_SUB ? a_q < b_q : 1'b0;
`endif

    // ra/rb are latched directly into the read-address registers, so the
    // register file sees them for exactly the FETCH cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            instr_ready  <= 1'b1;
            op_q         <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            address_a    <= '0;
            address_b    <= '0;
            write_enable <= 1'b0;
            address_w    <= '0;
            data_in_w    <= '0;
            done         <= 1'b0;
`ifdef OPERAND_SEQUENCER_FLAGS_EN
            carry_q      <= 1'b0;
            zero_flag    <= 1'b0;
            carry_flag   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        state       <= FETCH;
                        instr_ready <= 1'b0;
                        op_q        <= opcode;
                        rd_q        <= rd;
                        imm_q       <= imm;
                        address_a   <= ra;
                        address_b   <= rb;
                    end
                end
                FETCH: begin
                    state     <= EXEC;
                    a_q       <= data_out_a;
                    b_q       <= data_out_b;
                    address_a <= '0;
                    address_b <= '0;
                end
                EXEC: begin
                    state        <= WRITE;
                    write_enable <= op_q != OP_NOP;
                    address_w    <= rd_q;
                    data_in_w    <= alu_res;
                    done         <= 1'b1;
`ifdef OPERAND_SEQUENCER_FLAGS_EN
                    carry_q      <= alu_cy;
`endif
                end
                WRITE: begin
                    state        <= IDLE;
                    instr_ready  <= 1'b1;
                    write_enable <= 1'b0;
                    address_w    <= '0;
                    data_in_w    <= '0;
                    done         <= 1'b0;
`ifdef OPERAND_SEQUENCER_FLAGS_EN
                    // data_in_w still holds the result during WRITE
                    if (op_q <= OP_XOR) begin
                        zero_flag  <= data_in_w == '0;
                        carry_flag <= carry_q;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: randomized and directed self-checking bench with a register-file model and an ISA-level reference
module tb_operand_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  opcode = 3'd0;
    logic [3:0]  rd = 4'd0, ra = 4'd0, rb = 4'd0;
    logic [7:0]  imm = 8'd0;
    logic [3:0]  address_a, address_b, address_w;
    logic [15:0] data_out_a, data_out_b, data_in_w;
    logic        write_enable, done;
`ifdef OPERAND_SEQUENCER_FLAGS_EN
    logic        zero_flag, carry_flag;
`endif

    operand_sequencer #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .ra(ra), .rb(rb), .imm(imm),
        .address_a(address_a), .address_b(address_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .write_enable(write_enable), .address_w(address_w), .data_in_w(data_in_w), .done(done)
`ifdef OPERAND_SEQUENCER_FLAGS_EN
        , .zero_flag(zero_flag), .carry_flag(carry_flag)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // environment register file: written by the DUT, preloadable by the bench
    logic        pl_en = 1'b0;
    logic [3:0]  pl_addr = 4'd0;
    logic [15:0] pl_data = 16'd0;
    logic [15:0] rf [16];

    assign data_out_a = rf[address_a];
    assign data_out_b = rf[address_b];

    always @(posedge clk) begin
        if (write_enable) rf[address_w] <= data_in_w;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    int hs = 0;
    always @(posedge clk) if (reset && instr_valid && instr_ready) hs <= hs + 1;

    // reference: result of one instruction as {carry, value}
    function automatic logic [16:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] i);
        int x = int'(a);
        int y = int'(b);
        case (op)
            3'd0: return 17'(x + y);
            3'd1: return {x < y, 16'(x - y)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, a};
            3'd6: return {9'd0, i};
            default: return 17'd0;
        endcase
    endfunction

    // model: an accepted instruction retires three edges after its handshake;
    // since counts cycles elapsed since the handshake (0 = waiting for one)
    int          since = 0;
    logic [2:0]  m_op = 3'd7;
    logic [3:0]  m_rd = 4'd0, m_ra = 4'd0, m_rb = 4'd0;
    logic [15:0] m_res = 16'd0;
    logic        m_cy = 1'b0;
    logic        mz = 1'b0, mc = 1'b0;
    logic [15:0] mreg [16];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            since <= 0;
            mz    <= 1'b0;
            mc    <= 1'b0;
        end else if (pl_en) begin
            mreg[pl_addr] <= pl_data;
        end else if (since == 0) begin
            if (instr_valid) begin
                m_op <= opcode;
                m_rd <= rd;
                m_ra <= ra;
                m_rb <= rb;
                {m_cy, m_res} <= alu(opcode, mreg[ra], mreg[rb], imm);
                since <= 1;
            end
        end else if (since == 3) begin
            if (m_op != 3'd7) mreg[m_rd] <= m_res;
            if (m_op <= 3'd4) begin
                mz <= m_res == 16'd0;
                mc <= m_cy;
            end
            since <= 0;
        end else begin
            since <= since + 1;
        end
    end

    logic chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", 32'(instr_ready), 32'(since == 0));
            chk("addr_a", 32'(address_a), 32'(since == 1 ? m_ra : 4'd0));
            chk("addr_b", 32'(address_b), 32'(since == 1 ? m_rb : 4'd0));
            chk("we", 32'(write_enable), 32'(since == 3 && m_op != 3'd7));
            chk("done", 32'(done), 32'(since == 3));
            if (!(since == 3 && m_op == 3'd7)) begin
                chk("addr_w", 32'(address_w), 32'(since == 3 ? m_rd : 4'd0));
                chk("data_w", 32'(data_in_w), 32'(since == 3 ? m_res : 16'd0));
            end
`ifdef OPERAND_SEQUENCER_FLAGS_EN
            chk("zero_flag", 32'(zero_flag), 32'(mz));
            chk("carry_flag", 32'(carry_flag), 32'(mc));
`endif
        end
    end

    task automatic scramble();
        opcode = 3'($urandom);
        rd = 4'($urandom);
        ra = 4'($urandom);
        rb = 4'($urandom);
        imm = 8'($urandom);
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // returns at the negedge inside FETCH of the offered instruction
    task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] i);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        opcode = op;
        rd = d;
        ra = a;
        rb = b;
        imm = i;
        @(negedge clk);
        instr_valid = 1'b0;
        scramble();
    endtask

    initial begin
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        for (int k = 0; k < 16; k++) preload(4'(k), 16'($urandom));

        // LDI rd=3 imm=0xA5
        issue(3'd6, 4'd3, 4'd0, 4'd0, 8'hA5);
        repeat (2) @(negedge clk);
        chk("ldi_we", 32'(write_enable), 32'd1);
        chk("ldi_aw", 32'(address_w), 32'd3);
        chk("ldi_dw", 32'(data_in_w), 32'h00A5);
        chk("ldi_done", 32'(done), 32'd1);

        // ADD with carry-out wrapping to zero
        preload(4'd1, 16'hFFFF);
        preload(4'd2, 16'h0001);
        issue(3'd0, 4'd4, 4'd1, 4'd2, 8'h00);
        chk("add_aa", 32'(address_a), 32'd1);
        chk("add_ab", 32'(address_b), 32'd2);
        repeat (2) @(negedge clk);
        chk("add_aw", 32'(address_w), 32'd4);
        chk("add_dw", 32'(data_in_w), 32'h0000);
        @(negedge clk);
`ifdef OPERAND_SEQUENCER_FLAGS_EN
        chk("add_zf", 32'(zero_flag), 32'd1);
        chk("add_cf", 32'(carry_flag), 32'd1);
`endif

        // SUB with all three indices equal
        preload(4'd5, 16'h0003);
        issue(3'd1, 4'd5, 4'd5, 4'd5, 8'h00);
        repeat (2) @(negedge clk);
        chk("sub_aw", 32'(address_w), 32'd5);
        chk("sub_dw", 32'(data_in_w), 32'h0000);
        @(negedge clk);
`ifdef OPERAND_SEQUENCER_FLAGS_EN
        chk("sub_cf", 32'(carry_flag), 32'd0);
`endif

        // NOP: ready low for exactly three cycles, never writes
        issue(3'd7, 4'd6, 4'd0, 4'd0, 8'h00);
        chk("nop_rdy1", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("nop_rdy2", 32'(instr_ready), 32'd0);
        chk("nop_we2", 32'(write_enable), 32'd0);
        @(negedge clk);
        chk("nop_rdy3", 32'(instr_ready), 32'd0);
        chk("nop_we3", 32'(write_enable), 32'd0);
        chk("nop_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("nop_rdy4", 32'(instr_ready), 32'd1);

        // reset during EXEC abandons the ADD; valid offered during reset is ignored
        issue(3'd0, 4'd9, 4'd1, 4'd2, 8'h00);
        @(posedge clk);
        #2 reset = 1'b0;
        instr_valid = 1'b1;
        @(negedge clk);
        chk("rst_exec_we", 32'(write_enable), 32'd0);
        chk("rst_exec_rdy", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        instr_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_we", 32'(write_enable), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
        end
        issue(3'd6, 4'd9, 4'd0, 4'd0, 8'h3C);
        repeat (2) @(negedge clk);
        chk("ldi2_we", 32'(write_enable), 32'd1);
        chk("ldi2_aw", 32'(address_w), 32'd9);
        chk("ldi2_dw", 32'(data_in_w), 32'h003C);

        // back-to-back: valid held high, fields churning every cycle
        begin
            int base;
            int n = 0;
            @(negedge clk);
            while (!instr_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            base = hs;
            instr_valid = 1'b1;
            scramble();
            repeat (32) begin
                @(negedge clk);
                scramble();
            end
            instr_valid = 1'b0;
            chk("b2b_handshakes", 32'(hs - base), 32'd8);
        end

        // random traffic with occasional resets
        repeat (600) begin
            @(posedge clk);
            #2 reset = $urandom_range(0, 59) != 0;
            @(negedge clk);
            instr_valid = 1'($urandom);
            scramble();
        end
        @(posedge clk);
        #2 reset = 1'b1;
        instr_valid = 1'b0;
        repeat (6) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
